// File: rtl/slave_reg_arbiter.sv
// slave_reg_arbiter: shares the slave register-map port between the I2C engine (m0) and a local requester (m1)
module slave_reg_arbiter #(
    parameter bit          ARB_RR     = 1'b0,
    parameter int unsigned WAIT_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wen,
    output logic       reg_ren,
    input  logic [7:0] reg_rdata
);
    localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t     state_q, state_d;
    logic       sel_q, sel_d, last_q, last_d;
    logic       wen_q, wen_d, ren_q, ren_d, ack0_q, ack0_d, ack1_q, ack1_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
    logic       win, win_we;
    always_comb begin
        // win = 1 selects m1; a lone request always wins
        win     = (m0_req && m1_req) ? (ARB_RR ? !last_q : (wait_q == LIMIT)) : m1_req;
        win_we  = win ? m1_we : m0_we;
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                wait_d = (win || !m1_req) ? 4'd0 : (wait_q != LIMIT ? wait_q + 4'd1 : wait_q);
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    sel_d   = win;
                    last_d  = win;
                    addr_d  = win ? m1_addr : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    wen_d   = win_we;
                    ren_d   = !win_we;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rd0_d   = (ren_q && !sel_q) ? reg_rdata : rd0_q;
                rd1_d   = (ren_q && sel_q) ? reg_rdata : rd1_q;
                ack0_d  = !sel_q;
                ack1_d  = sel_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            wait_q  <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= 8'h00;
            rd1_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wen   = wen_q;
    assign reg_ren   = ren_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rd0_q;
    assign m1_rdata  = rd1_q;
endmodule

// File: doc/slave_reg_arbiter.md
Name: slave_reg_arbiter

Overview:
- Shares the slave register-map access port (reg_addr/reg_wdata/reg_wen/reg_ren/reg_rdata) between two requesters.
- m0 is the I2C slave protocol engine; m1 is a local requester (on-board debug/UART bridge).
- Serialises single-byte accesses with a req/ack handshake and returns read data.
- Fixed priority with anti-starvation, or round-robin, selected by parameter.

Parameters:
- ARB_RR, 0: 0 = m0 priority with starvation guard; 1 = round-robin between m0 and m1.
- WAIT_LIMIT, 4: in fixed mode, number of consecutive m0 grants issued while m1 waits, after which m1 wins the next arbitration. Range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m0_req  input  1  m0 access request; held with addr/we/wdata stable until m0_ack
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  8  register address
- m0_wdata  input  8  write data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  8  read data, valid in the m0_ack cycle and held until m0's next read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0 for requester 1
- reg_addr  output  8  to register map
- reg_wdata  output  8  to register map
- reg_wen  output  1  write strobe to register map
- reg_ren  output  1  read strobe to register map
- reg_rdata  input  8  combinational read data from register map

Behaviour:
- Reset values (async, while rst_n = 0):
  - reg_addr, reg_wdata, m0_rdata, m1_rdata = 8'h00
  - reg_wen, reg_ren, m0_ack, m1_ack = 0
  - FSM = IDLE, wait_cnt = 0, last_grant = m1 (so m0 wins first in RR mode)
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles. No back-to-back overlap.
- IDLE:
  - If any req is high, pick the winner, register sel, and latch the winner's addr/wdata into reg_addr/reg_wdata.
  - Register reg_wen = we or reg_ren = !we.
  - Go to ACCESS.
  - With no req, stay in IDLE; strobes stay 0.
- ACCESS:
  - Exactly one of reg_wen/reg_ren is high for this single cycle.
  - On a read, sample reg_rdata into the winner's mX_rdata at the end of the cycle.
  - Clear strobes. Go to RESP.
- RESP:
  - The winner's mX_ack = 1 for exactly one cycle; the loser's ack stays 0. Go to IDLE.
- Handshake:
  - Requester drops req at the clock edge where it samples ack = 1.
  - A req still high in the IDLE cycle after ack is a new transaction.
  - Inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- Latency: req sampled high in IDLE at cycle t -> strobe at t+1 -> ack at t+2.
- The non-winner's mX_rdata is never modified. Write transactions do not alter mX_rdata.
- reg_addr/reg_wdata hold their last values outside ACCESS.
- Arbitration, only when both reqs are high:
  - RR mode: grant the requester other than last_grant. last_grant updates on every grant.
  - Fixed mode: m0 wins unless wait_cnt == WAIT_LIMIT, in which case m1 wins.
  - wait_cnt increments (saturating at WAIT_LIMIT) on each m0 grant made while m1_req is high.
  - wait_cnt clears on any m1 grant, and on any IDLE cycle where m1_req = 0.
- Single request: always granted regardless of mode or wait_cnt.
- Addresses are passed through unmodified; read-only/unmapped handling belongs to the register map. Writes to 0x00 still issue reg_wen and still ack.
- Reset mid-transaction: abort immediately. No ack or strobe is issued after rst_n falls; the FSM restarts in IDLE after release.

Test Plan:
- Single write: m0 writes addr 0x01 data 0xA5 -> reg_wen high 1 cycle with reg_addr = 0x01, reg_wdata = 0xA5; m0_ack 2 cycles after sampling; map LED[7:0] = 0xA5.
- Single read: m1 reads 0x02 after LED_HIGH = 0x3C -> reg_ren 1 cycle; m1_ack with m1_rdata = 0x3C; m0_rdata unchanged at 0x00.
- Simultaneous, ARB_RR = 1: both req continuously (m0 write 0x03 / m1 read 0x00) -> grants alternate m0, m1, m0, m1; one ack every 3 cycles; never two acks in one cycle.
- Fixed priority, starvation: ARB_RR = 0, WAIT_LIMIT = 4, both req held, m0 re-requests immediately after each ack -> grant order m0, m0, m0, m0, m1, then m0 x4 again.
- Reset mid-op: assert rst_n = 0 during ACCESS of an m0 write -> reg_wen/m0_ack drop at once; after release no ack for the aborted transaction; outputs at reset values.
- Idle/no-req: no requests for 20 cycles -> reg_wen = reg_ren = 0, acks 0, reg_addr holds its last value.
